// File: rtl/ir_fetch_ctrl_if.sv
// Word-wide memory bus used by the instruction fetch controller.
// The master (fetch controller) issues reads; the slave (memory) answers
// with waitrequest stalls and readdata.
interface ir_fetch_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch controller: issues one bus read per fetch request,
// rides out waitrequest stalls, captures the returned word into the
// instruction register and holds it until the decode path accepts it.
// A flush abandons the current fetch; a read already on the bus is
// drained and its data thrown away. Misaligned PCs and over-long stalls
// park the block in a sticky error state that only reset leaves.
module ir_fetch_ctrl #(
  parameter int          MAX_WAIT = 255,
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_req,
  input  logic [31:0]             fetch_pc,
  input  logic                    flush,
  input  logic                    ir_ack,
  ir_fetch_ctrl_if.master         bus,
  output logic [31:0]             ir_word,
  output logic                    ir_valid,
  output logic                    busy,
  output logic                    fetch_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  // Counter value on which one more stall cycle hits the limit.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        address_reg, address_next;
  logic               read_reg, read_next;
  logic [31:0]        ir_word_reg, ir_word_next;
  logic               ir_valid_reg, ir_valid_next;
  logic               err_reg, err_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               launch;
  logic [3:0]         be;

  // State and datapath registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      address_reg  <= 32'h0;
      read_reg     <= 1'b0;
      ir_word_reg  <= IR_RESET;
      ir_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      address_reg  <= address_next;
      read_reg     <= read_next;
      ir_word_reg  <= ir_word_next;
      ir_valid_reg <= ir_valid_next;
      err_reg      <= err_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state and next-register logic; a new fetch can start from IDLE or
  // straight out of HOLD once the held word is released (ack or flush).
  always_comb begin
    state_next    = state_reg;
    address_next  = address_reg;
    read_next     = read_reg;
    ir_word_next  = ir_word_reg;
    ir_valid_next = ir_valid_reg;
    err_next      = err_reg;
    wait_cnt_next = wait_cnt_reg;
    launch        = 1'b0;

    case (state_reg)
      IDLE: begin
        launch = fetch_req;
      end
      REQ: begin
        if (!bus.waitrequest) begin
          read_next  = 1'b0;
          state_next = IDLE;
          // A flush in the completing cycle discards the word.
          if (!flush) begin
            ir_word_next  = bus.readdata;
            ir_valid_next = 1'b1;
            state_next    = HOLD;
          end
        end else if (flush) begin
          // The read cannot be withdrawn mid-stall: keep it up and drop the data.
          state_next    = DRAIN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          err_next   = 1'b1;
          read_next  = 1'b0;
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
      end
      HOLD: begin
        // flush outranks ir_ack, but both release the held word.
        if (flush || ir_ack) begin
          ir_valid_next = 1'b0;
          state_next    = IDLE;
          launch        = fetch_req;
        end
      end
      DRAIN: begin
        if (!bus.waitrequest) begin
          read_next  = 1'b0;
          state_next = IDLE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          err_next   = 1'b1;
          read_next  = 1'b0;
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
      end
      ERR: begin
        read_next     = 1'b0;
        ir_valid_next = 1'b0;
        err_next      = 1'b1;
      end
      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
      end
    endcase

    if (launch) begin
      if (fetch_pc[1:0] != 2'b00) begin
        err_next   = 1'b1;
        read_next  = 1'b0;
        state_next = ERR;
      end else begin
        address_next  = fetch_pc;
        read_next     = 1'b1;
        wait_cnt_next = '0;
        state_next    = REQ;
      end
    end
  end

  // Every byte lane is enabled whenever a read is on the bus.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
      assign be[gi] = read_reg;
    end
  endgenerate

  assign bus.address    = address_reg;
  assign bus.read       = read_reg;
  assign bus.byteenable = be;
  assign ir_word        = ir_word_reg;
  assign ir_valid       = ir_valid_reg;
  assign busy           = (state_reg != IDLE);
  assign fetch_err      = err_reg;

endmodule
